// File: rtl/morse_char_sequencer.sv
// Buffers received bytes and feeds them one at a time to morse_generator, adding the
// inter-letter gap and a watchdog. Optional macro MORSE_SEQ_UPPERCASE_EN folds 'a'-'z' on write.
module morse_char_sequencer #(
    parameter int MORSE_CYCLES   = 10,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 64 * MORSE_CYCLES
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic [7:0]                    ascii_o,
    output logic                          en_o,
    input  logic                          gen_done_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic                          timeout_o
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int GAP_LEN = 2 * MORSE_CYCLES;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_LEN) ? TIMEOUT_CYCLES : GAP_LEN;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {IDLE, SEND, BUSY, GAP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [LW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level;
    logic [7:0]      ascii_q, wr_data;
    logic            en_q, en_d, ovf_q, ovf_d, to_q, to_d;
    logic [CW-1:0]   wd_q, wd_d, gap_q, gap_d;
    logic            empty, full, pop, wr_en;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == LW'(FIFO_DEPTH));

`ifdef MORSE_SEQ_UPPERCASE_EN
    always_comb begin
        wr_data = data_i;
        if (data_i >= 8'h61 && data_i <= 8'h7A) begin
            wr_data = data_i - 8'h20;
        end
    end
`else
    assign wr_data = data_i;
`endif

    // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
    assign wr_en = valid_i && (!full || pop);

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        wd_d     = wd_q;
        gap_d    = gap_q;
        to_d     = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    en_d    = 1'b1;
                    wd_d    = '0;
                    state_d = SEND;
                end
            end
            SEND, BUSY: begin
                if (state_q == BUSY && gen_done_i) begin
                    en_d    = 1'b0;
                    gap_d   = (ascii_q != SPACE) ? CW'(GAP_LEN) : '0;
                    state_d = GAP;
                end else if (wd_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    en_d    = 1'b0;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (state_q == SEND && !gen_done_i) begin
                        state_d = BUSY;
                    end
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (!gen_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = valid_i && full && !pop;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            wd_q     <= '0;
            gap_q    <= '0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            wd_q     <= wd_d;
            gap_q    <= gap_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Registered read-first port: when full, the popped head is read before the new byte lands.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ascii_q <= '0;
        end else if (pop) begin
            ascii_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign ascii_o    = ascii_q;
    assign en_o       = en_q;
    assign level_o    = level;
    assign busy_o     = (state_q != IDLE) || !empty;
    assign overflow_o = ovf_q;
    assign timeout_o  = to_q;

endmodule

// File: tb/tb_morse_char_sequencer.sv
// Bench for morse_char_sequencer: queue/timestamp reference model checked every cycle,
// a small morse_generator stand-in, and directed scenarios with literal expectations.
module tb_morse_char_sequencer;
    localparam int MC      = 2;
    localparam int DEPTH   = 4;
    localparam int TO      = 20;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int GEN_RUN = 6;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [7:0]    data_i = '0;
    logic          valid_i = 1'b0;
    logic          gen_done_i;
    logic [7:0]    ascii_o;
    logic          en_o;
    logic [LW-1:0] level_o;
    logic          busy_o, overflow_o, timeout_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    morse_char_sequencer #(.MORSE_CYCLES(MC), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ascii_o(ascii_o), .en_o(en_o), .gen_done_i(gen_done_i), .level_o(level_o),
        .busy_o(busy_o), .overflow_o(overflow_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator stand-in: runs GEN_RUN cycles after seeing en, holds done until en drops.
    int   g_state = 0;
    int   g_cnt = 0;
    bit   stall = 1'b0;
    always @(posedge clk) begin
        if (reset_i) begin
            g_state    <= 0;
            g_cnt      <= 0;
            gen_done_i <= 1'b0;
        end else begin
            case (g_state)
                0: if (en_o) begin g_state <= 1; g_cnt <= GEN_RUN; end
                1: begin
                    if (!en_o) g_state <= 0;
                    else if (!stall) begin
                        if (g_cnt == 0) begin g_state <= 2; gen_done_i <= 1'b1; end
                        else g_cnt <= g_cnt - 1;
                    end
                end
                default: if (!en_o) begin g_state <= 0; gen_done_i <= 1'b0; end
            endcase
        end
    end

    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef MORSE_SEQ_UPPERCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    // Reference model: a byte queue plus edge timestamps derived from the timing rules.
    logic [7:0] mq[$];
    logic [7:0] m_ascii;
    bit   m_en, m_ovf, m_to, m_idle, m_wait_rel, m_low_seen, m_valid;
    int   m_rise, m_rel_at, e;

    always @(posedge clk) begin
        if (reset_i) begin
            mq.delete();
            m_ascii = 8'h00; m_en = 0; m_ovf = 0; m_to = 0;
            m_idle = 1; m_wait_rel = 0; m_low_seen = 0; m_valid = 1;
        end else if (m_valid) begin
            e = cyc + 1;
            m_ovf = 0;
            m_to  = 0;
            if (m_en) begin
                if (m_low_seen && gen_done_i) begin
                    m_en = 0; m_wait_rel = 1;
                    m_rel_at = e + ((m_ascii == 8'h20) ? 0 : 2 * MC) + 1;
                end else if (e - m_rise == TO) begin
                    m_en = 0; m_to = 1; m_wait_rel = 1; m_rel_at = e + 1;
                end else if (!gen_done_i) begin
                    m_low_seen = 1;
                end
            end else if (m_wait_rel) begin
                if (e >= m_rel_at && !gen_done_i) begin m_wait_rel = 0; m_idle = 1; end
            end else if (m_idle && mq.size() > 0) begin
                m_ascii = mq.pop_front();
                m_en = 1; m_rise = e; m_low_seen = 0; m_idle = 0;
            end
            if (valid_i) begin
                if (mq.size() < DEPTH) mq.push_back(fold(data_i));
                else m_ovf = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, plus event monitors.
    bit en_prev = 0;
    int last_rise = 0;
    int ovf_cnt = 0;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ascii_o", {24'd0, ascii_o}, {24'd0, m_ascii});
            chk("en_o", {31'd0, en_o}, {31'd0, m_en});
            chk("level_o", 32'(level_o), 32'(mq.size()));
            chk("busy_o", {31'd0, busy_o}, {31'd0, (!m_idle || mq.size() > 0)});
            chk("overflow_o", {31'd0, overflow_o}, {31'd0, m_ovf});
            chk("timeout_o", {31'd0, timeout_o}, {31'd0, m_to});
            if (en_o && !en_prev) begin
                chk("en_rise_done_low", {31'd0, gen_done_i}, 32'd0);
                last_rise = cyc;
                $display("cycle %0d: sent 8'h%02h", cyc, ascii_o);
            end
            if (overflow_o) ovf_cnt++;
        end
        en_prev = en_o;
    end

    task automatic write_byte(input logic [7:0] b);
        data_i  = b;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        $display("cycle %0d: wrote 8'h%02h", cyc, b);
    endtask

    // which: 0 en_o, 1 gen_done_i, 2 timeout_o, 3 busy_o
    task automatic wait_sig(input int which, input logic val, input int budget,
                            input string name, output int at);
        logic s;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (which)
                0: s = en_o;
                1: s = gen_done_i;
                2: s = timeout_o;
                default: s = busy_o;
            endcase
            if (s == val) begin
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_%s at cycle %0d: got no change expected %0b within %0d cycles",
                 name, cyc, val, budget);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit at cycle %0d: got running expected finished", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "time limit");
    end

    int t_d, t_r, t_t, t_x;
    logic [7:0] ab_seq [3];
    logic [7:0] ovf_seq [6];

    initial begin
        ab_seq  = '{8'h41, 8'h20, 8'h42};
        ovf_seq = '{8'h7E, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        repeat (3) @(negedge clk);
        chk("rst_ascii", {24'd0, ascii_o}, 32'd0);
        chk("rst_en", {31'd0, en_o}, 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ovf_to", {30'd0, overflow_o, timeout_o}, 32'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // 'E' then 'T': pop one cycle after write, 2*MC+3 from done rise to next en rise.
        write_byte(8'h45);
        chk("E_level_after_write", 32'(level_o), 32'd1);
        chk("E_en_after_write", {31'd0, en_o}, 32'd0);
        write_byte(8'h54);
        chk("E_en_rise", {31'd0, en_o}, 32'd1);
        chk("E_ascii", {24'd0, ascii_o}, 32'h45);
        wait_sig(1, 1'b1, 40, "E_done", t_d);
        @(negedge clk);
        chk("E_en_fall", {31'd0, en_o}, 32'd0);
        wait_sig(0, 1'b1, 40, "T_en", t_r);
        chk("letter_gap", t_r - t_d, 32'd7);
        chk("T_ascii", {24'd0, ascii_o}, 32'h54);
        wait_sig(3, 1'b0, 100, "idle1", t_x);

        // "A B": no gap after the space beyond the generator's done-release cycle.
        write_byte(ab_seq[0]);
        write_byte(ab_seq[1]);
        write_byte(ab_seq[2]);
        t_d = -1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0 || !en_o) wait_sig(0, 1'b1, 60, "AB_en", t_r);
            else t_r = cyc;
            if (i == 2) chk("space_gap", t_r - t_d, 32'd4);
            if (i == 1) chk("A_gap", t_r - t_d, 32'd7);
            chk("AB_ascii", {24'd0, ascii_o}, {24'd0, ab_seq[i]});
            wait_sig(1, 1'b1, 40, "AB_done", t_d);
        end
        wait_sig(3, 1'b0, 100, "idle2", t_x);

        // Stalled generator: overflow and watchdog.
        stall = 1'b1;
        ovf_cnt = 0;
        for (int i = 0; i < 6; i++) write_byte(ovf_seq[i]);
        chk("ovf_level_peak", 32'(level_o), 32'd4);
        chk("ovf_pulse", {31'd0, overflow_o}, 32'd1);
        @(negedge clk);
        chk("ovf_count", ovf_cnt, 32'd1);
        chk("ovf_pulse_len", {31'd0, overflow_o}, 32'd0);
        wait_sig(2, 1'b1, 60, "timeout", t_t);
        chk("timeout_delay", t_t - last_rise, 32'(TO));
        chk("timeout_en_drop", {31'd0, en_o}, 32'd0);
        wait_sig(0, 1'b1, 20, "after_to_en", t_r);
        chk("after_to_ascii", {24'd0, ascii_o}, 32'h31);
        stall = 1'b0;
        wait_sig(3, 1'b0, 400, "idle3", t_x);

        // Reset while BUSY.
        write_byte(8'h45);
        wait_sig(0, 1'b1, 10, "rst_en", t_r);
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        chk("midrst_en", {31'd0, en_o}, 32'd0);
        chk("midrst_level", 32'(level_o), 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        reset_i = 1'b0;
        @(negedge clk);
        write_byte(8'h54);
        wait_sig(0, 1'b1, 10, "postrst_en", t_r);
        chk("postrst_ascii", {24'd0, ascii_o}, 32'h54);
        wait_sig(3, 1'b0, 100, "idle4", t_x);

        // Lower-case folding.
        write_byte(8'h71);
        wait_sig(0, 1'b1, 10, "q_en", t_r);
`ifdef MORSE_SEQ_UPPERCASE_EN
        chk("q_ascii", {24'd0, ascii_o}, 32'h51);
`else
        chk("q_ascii", {24'd0, ascii_o}, 32'h71);
`endif
        wait_sig(3, 1'b0, 100, "idle5", t_x);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
